sha256_round_ctrl: RTL
======================

SHA256_ROUND_CTRL -- requirements
Module: sha256_round_ctrl

Interface
REQ-001 Parameters: none; SHA-256 round count 64 and message word count 16 SHALL be fixed constants.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 start  input  1  request to compress one 512-bit block; accepted only when ready=1.
REQ-005 first_blk  input  1  block is first of a message; sampled with accepted start (used only with SHA256_CTRL_MULTIBLOCK_EN).
REQ-006 abort  input  1  synchronous cancel of the block in progress.
REQ-007 w_valid  input  1  message word present on the schedule input.
REQ-008 ready  output  1  controller idle, start will be accepted.
REQ-009 busy  output  1  block in progress (~ready).
REQ-010 w_ready  output  1  controller consumes the message word this cycle.
REQ-011 k_idx  output  6  round index driven to the round-constant table.
REQ-012 round_en  output  1  compression datapath executes round k_idx this cycle.
REQ-013 w_load  output  1  schedule takes the external word (rounds 0-15), else the expanded word.
REQ-014 hash_init  output  1  load H0-H7 initial values into the hash registers.
REQ-015 hash_update  output  1  add working variables a-h into the hash registers.
REQ-016 done  output  1  one-cycle pulse: digest registers valid.

Function
REQ-017 The FSM SHALL have states IDLE, INIT, ROUND, FINAL, DONE; all outputs SHALL be registered or decoded from state/counter only (no input-to-output combinational path except w_ready and round_en, as given in REQ-020).
REQ-018 IDLE: ready=1; start=1 -> INIT, round counter cleared to 0, first_blk captured; start in any other state SHALL be ignored.
REQ-019 INIT (one cycle): hash_init=1 per REQ-030/031, also loads a-h from the hash registers; -> ROUND.
REQ-020 ROUND, counter<16: w_ready=1, w_load=1, round_en=w_valid; counter advances only when w_valid=1, else the round stalls with k_idx held.
REQ-021 ROUND, counter>=16: w_ready=0, w_load=0, round_en=1 every cycle, w_valid ignored.
REQ-022 k_idx SHALL equal the round counter in ROUND and 0 in all other states.
REQ-023 Round counter is 6 bits; after the round with k_idx=63 executes, the counter SHALL wrap to 0 and the FSM -> FINAL.
REQ-024 FINAL (one cycle): hash_update=1; -> DONE.
REQ-025 DONE (one cycle): done=1, ready=0; -> IDLE.
REQ-026 Latency with w_valid held high: start accepted at edge 0; INIT cycle 1; ROUND cycles 2-65; FINAL cycle 66; done=1 cycle 67; ready=1 cycle 68; every w_valid=0 cycle during rounds 0-15 adds one cycle.
REQ-027 abort=1 in INIT/ROUND/FINAL SHALL force IDLE next edge with no hash_update and no done; abort in IDLE/DONE SHALL have no effect; abort has priority over round advance.
REQ-028 Exactly 16 words SHALL be consumed per completed block; no w_ready outside ROUND rounds 0-15.

Reset
REQ-029 rst_n=0 SHALL immediately force IDLE, counter=0, captured first_blk=0; outputs ready=1, busy=0, all others 0; reset mid-block discards the block with no done.

Configuration
REQ-030 Macro SHA256_CTRL_MULTIBLOCK_EN defined: hash_init=1 in INIT only if captured first_blk=1, otherwise hash registers chain from the previous block.
REQ-031 Macro undefined: first_blk SHALL be ignored and hash_init=1 in every INIT (single-block messages only).

Verification
REQ-032 Reset then start=1, w_valid=1 constant -> done=1 on cycle 67, 16 w_ready pulses, k_idx sequence 0..63 on consecutive round_en cycles, one hash_update on cycle 66.
REQ-033 w_valid=0 for 3 cycles at round 5 -> k_idx holds 5, round_en=0 for those cycles, done delayed to cycle 70.
REQ-034 abort=1 at round 40 -> IDLE next cycle, ready=1, no hash_update, no done; new start then completes normally.
REQ-035 With macro: block1 first_blk=1 -> hash_init=1; block2 first_blk=0 -> hash_init=0; without macro both -> hash_init=1.
REQ-036 rst_n=0 at round 20 -> outputs to reset values asynchronously; start during busy -> ignored, exactly one done per accepted start.

Source files
------------

// File: rtl/sha256_round_ctrl.sv
// Purpose : round sequencer for a SHA-256 compression core (IDLE/INIT/ROUND/FINAL/DONE).
// Latency : start accepted at edge 0 -> INIT, 64 rounds, FINAL, done pulse 67 cycles later (+1 per w_valid stall).
// Backpr. : rounds 0-15 stall with k_idx held while w_valid=0; rounds 16-63 never stall.
//
// Optional build macro: SHA256_CTRL_MULTIBLOCK_EN
//   defined   -> hash_init only on blocks started with first_blk=1 (chained multi-block messages)
//   undefined -> hash_init on every block, first_blk ignored
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   start         request one block; taken only while ready=1
//   first_blk     block opens a new message (sampled with start)
//   abort         cancel block in INIT/ROUND/FINAL, back to IDLE next edge
//   w_valid       message word available on the schedule input
//   ready / busy  idle indication and its inverse
//   w_ready       word consumed this cycle (rounds 0-15 only)
//   k_idx         round index for the K table (0 outside ROUND)
//   round_en      datapath executes round k_idx this cycle
//   w_load        schedule selects the external word instead of the expanded one
//   hash_init     load H0-H7 initial values
//   hash_update   accumulate a-h into the hash registers
//   done          one-cycle pulse, digest valid
module sha256_round_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       first_blk,
  input  logic       abort,
  input  logic       w_valid,
  output logic       ready,
  output logic       busy,
  output logic       w_ready,
  output logic [5:0] k_idx,
  output logic       round_en,
  output logic       w_load,
  output logic       hash_init,
  output logic       hash_update,
  output logic       done
);

  localparam logic [5:0] NUM_WORDS  = 6'd16;
  localparam logic [5:0] LAST_ROUND = 6'd63;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    INIT  = 3'd1,
    ROUND = 3'd2,
    FINAL = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t     state;
  logic [5:0] rnd_cnt;
  logic       in_round;
  logic       word_phase;
  logic       advance;
  logic       init_req;

  assign in_round   = (state == ROUND);
  assign word_phase = (rnd_cnt < NUM_WORDS);
  // Schedule rounds wait for a word; expansion rounds run every cycle.
  assign advance    = in_round && (!word_phase || w_valid);

`ifdef SHA256_CTRL_MULTIBLOCK_EN
  // Later blocks of a message keep chaining from the previous digest.
  assign init_req = first_blk;
`else
  logic first_blk_unused;
  assign first_blk_unused = first_blk;
  assign init_req = 1'b1;
`endif

  // ready, hash_init, hash_update and done are registered alongside the
  // state: each is set on the edge that enters its state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      rnd_cnt     <= '0;
      ready       <= 1'b1;
      hash_init   <= 1'b0;
      hash_update <= 1'b0;
      done        <= 1'b0;
    end else begin
      ready       <= 1'b0;
      hash_init   <= 1'b0;
      hash_update <= 1'b0;
      done        <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= INIT;
            rnd_cnt   <= '0;
            hash_init <= init_req;
          end else begin
            ready <= 1'b1;
          end
        end
        INIT: begin
          if (abort) begin
            state <= IDLE;
            ready <= 1'b1;
          end else begin
            state <= ROUND;
          end
        end
        ROUND: begin
          if (abort) begin
            state   <= IDLE;
            rnd_cnt <= '0;
            ready   <= 1'b1;
          end else if (advance) begin
            // 6-bit counter wraps 63 -> 0 on the last round.
            rnd_cnt <= rnd_cnt + 6'd1;
            if (rnd_cnt == LAST_ROUND) begin
              state       <= FINAL;
              hash_update <= 1'b1;
            end
          end
        end
        FINAL: begin
          if (abort) begin
            state <= IDLE;
            ready <= 1'b1;
          end else begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          ready <= 1'b1;
        end
        default: begin
          state <= IDLE;
          ready <= 1'b1;
        end
      endcase
    end
  end

  assign busy     = ~ready;
  assign w_ready  = in_round && word_phase;
  assign w_load   = in_round && word_phase;
  assign round_en = advance;
  assign k_idx    = in_round ? rnd_cnt : 6'd0;

endmodule
